// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - buffers one conv output-channel map and streams it pixel by pixel with optional ReLU
module conv_result_streamer #(
    parameter int N     = 24,
    parameter int Q     = 13,
    parameter int OH    = 16,
    parameter int OW    = 80,
    parameter int OUTCH = 128,
    parameter int RELU  = 1,
    localparam int NPIX = OH * OW,
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int CW   = (OUTCH > 1) ? $clog2(OUTCH) : 1
) (
    input  logic                clk,
    input  logic                global_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*NPIX-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_data,
    output logic                out_last_pix,
    output logic                out_last_ch,
    output logic [CW-1:0]       out_ch,
    output logic [31:0]         relu_clip_cnt
);

    typedef enum logic {S_IDLE, S_STREAM} state_e;

    state_e                     state_q, state_d;
    logic [NPIX-1:0][N-1:0]     buf_q;
    logic [PW-1:0]              pix_cnt_q;
    logic [CW-1:0]              ch_cnt_q;
    logic [31:0]                clip_cnt_q;

    logic [N-1:0]               cur_pix;
    logic                       clamp;
    logic                       last_pix;
    logic                       last_ch;
    logic                       beat_xfer;
    logic                       in_hs;

    // Select the pixel under the read pointer and decide whether ReLU zeroes it (sign bit only)
    always_comb begin
        cur_pix   = buf_q[pix_cnt_q];
        clamp     = (RELU != 0) && cur_pix[N-1];
        last_pix  = (pix_cnt_q == PW'(NPIX - 1));
        last_ch   = (ch_cnt_q == CW'(OUTCH - 1));
        beat_xfer = (state_q == S_STREAM) && out_ready;
        in_hs     = in_valid && in_ready;
    end

    // State register
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a new map on the final beat keeps streaming without a bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_STREAM;
            S_STREAM: if (beat_xfer && last_pix) state_d = in_valid ? S_STREAM : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs; in_ready opens on the last pixel only when that beat is being taken
    always_comb begin
        in_ready      = 1'b1;
        out_valid     = 1'b0;
        out_last_pix  = 1'b0;
        if (state_q == S_STREAM) begin
            in_ready     = last_pix && out_ready;
            out_valid    = 1'b1;
            out_last_pix = last_pix;
        end
        out_data      = clamp ? '0 : cur_pix;
        out_last_ch   = last_ch;
        out_ch        = ch_cnt_q;
        relu_clip_cnt = clip_cnt_q;
    end

    // Map buffer and counters; ch_cnt advances only when a channel's last beat leaves
    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            buf_q      <= '0;
            pix_cnt_q  <= '0;
            ch_cnt_q   <= '0;
            clip_cnt_q <= '0;
        end else begin
            if (beat_xfer) begin
                if (clamp && (clip_cnt_q != 32'hFFFF_FFFF)) begin
                    clip_cnt_q <= clip_cnt_q + 32'd1;
                end
                if (last_pix) begin
                    pix_cnt_q <= '0;
                    ch_cnt_q  <= last_ch ? '0 : ch_cnt_q + CW'(1);
                end else begin
                    pix_cnt_q <= pix_cnt_q + PW'(1);
                end
            end
            if (in_hs) begin
                buf_q     <= in_data;
                pix_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_result_streamer.sv
// tb/tb_conv_result_streamer.sv - self-checking bench for conv_result_streamer against a beat-queue model
module tb_conv_result_streamer;

    localparam int N     = 24;
    localparam int OH    = 2;
    localparam int OW    = 2;
    localparam int NPIX  = OH * OW;
    localparam int OUTCH = 3;
    localparam int W     = N * NPIX;

    logic            clk = 1'b0;
    logic            global_rst;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            out_ready;

    logic            in_ready, out_valid, out_last_pix, out_last_ch;
    logic [N-1:0]    out_data;
    logic [1:0]      out_ch;
    logic [31:0]     relu_clip_cnt;

    logic            in_ready0, out_valid0, out_last_pix0, out_last_ch0;
    logic [N-1:0]    out_data0;
    logic [1:0]      out_ch0;
    logic [31:0]     relu_clip_cnt0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] raw;
        logic         lp;
        int           ch;
    } beat_t;

    beat_t exp_q[$];
    int    m_next_ch;
    int    m_clip;
    logic  acc;

    always #5 clk = ~clk;

    conv_result_streamer #(.N(N), .Q(13), .OH(OH), .OW(OW), .OUTCH(OUTCH), .RELU(1)) dut (
        .clk(clk), .global_rst(global_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last_pix(out_last_pix), .out_last_ch(out_last_ch), .out_ch(out_ch),
        .relu_clip_cnt(relu_clip_cnt)
    );

    conv_result_streamer #(.N(N), .Q(13), .OH(OH), .OW(OW), .OUTCH(OUTCH), .RELU(0)) dut0 (
        .clk(clk), .global_rst(global_rst),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_last_pix(out_last_pix0), .out_last_ch(out_last_ch0), .out_ch(out_ch0),
        .relu_clip_cnt(relu_clip_cnt0)
    );

    function automatic logic [N-1:0] relu(input logic [N-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    function automatic logic [W-1:0] rand_map();
        logic [W-1:0] m;
        for (int k = 0; k < NPIX; k++) begin
            case ($urandom_range(0, 3))
                0:       m[N*k +: N] = 24'h800000;
                1:       m[N*k +: N] = 24'h7FFFFF;
                default: m[N*k +: N] = N'($urandom);
            endcase
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare against the model, then advance the model
    task automatic step(input logic iv, input logic [W-1:0] mp, input logic ordy, output logic accepted);
        logic  ev, eir;
        beat_t b;
        @(negedge clk);
        in_valid  = iv;
        in_data   = mp;
        out_ready = ordy;
        #1;
        ev  = (exp_q.size() != 0);
        eir = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(eir));
        chk("relu_clip_cnt", relu_clip_cnt, 32'(m_clip));
        chk("out_valid_norelu", 32'(out_valid0), 32'(ev));
        chk("in_ready_norelu", 32'(in_ready0), 32'(eir));
        chk("relu_clip_cnt_norelu", relu_clip_cnt0, 32'd0);
        if (ev) begin
            b = exp_q[0];
            chk("out_data", 32'(out_data), 32'(relu(b.raw)));
            chk("out_last_pix", 32'(out_last_pix), 32'(b.lp));
            chk("out_last_ch", 32'(out_last_ch), 32'(b.ch == OUTCH - 1));
            chk("out_ch", 32'(out_ch), 32'(b.ch));
            chk("out_data_norelu", 32'(out_data0), 32'(b.raw));
            chk("out_ch_norelu", 32'(out_ch0), 32'(b.ch));
            if (ordy) begin
                if ($signed(b.raw) < 0) m_clip++;
                void'(exp_q.pop_front());
            end
        end
        accepted = iv && eir;
        if (accepted) begin
            for (int k = 0; k < NPIX; k++) begin
                b.raw = mp[N*k +: N];
                b.lp  = (k == NPIX - 1);
                b.ch  = m_next_ch;
                exp_q.push_back(b);
            end
            m_next_ch = (m_next_ch + 1) % OUTCH;
        end
    endtask

    // Assert reset between clock edges and check that everything clears without waiting for a clock
    task automatic do_reset();
        @(negedge clk);
        global_rst = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last_pix", 32'(out_last_pix), 32'd0);
        chk("rst_out_last_ch", 32'(out_last_ch), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_clip", relu_clip_cnt, 32'd0);
        exp_q.delete();
        m_next_ch = 0;
        m_clip    = 0;
        @(negedge clk);
        global_rst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] map_a, junk;
        logic [W-1:0] maps [4];
        int idx;

        global_rst = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        m_next_ch  = 0;
        m_clip     = 0;
        map_a = {24'h800000, 24'h7FFFFF, 24'hFFFF00, 24'h000100};

        do_reset();

        step(1'b1, map_a, 1'b1, acc);
        chk("accept_map_a", 32'(acc), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, acc);
        chk("clip_after_map_a", relu_clip_cnt, 32'd2);
        chk("clip_norelu_after_map_a", relu_clip_cnt0, 32'd0);

        step(1'b1, rand_map(), 1'b1, acc);
        for (int i = 0; i < 16; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), acc);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        do_reset();
        for (int i = 0; i < 4; i++) maps[i] = rand_map();
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            step(idx < 4, maps[idx < 4 ? idx : 0], 1'b1, acc);
            if (acc) idx++;
        end
        chk("b2b_accepts", 32'(idx), 32'd4);

        do_reset();
        step(1'b1, rand_map(), 1'b1, acc);
        idx = 0;
        junk = rand_map();
        for (int i = 0; i < 8 && idx == 0; i++) begin
            step(1'b1, junk, 1'b1, acc);
            if (acc) idx++;
        end
        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        do_reset();
        step(1'b1, map_a, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, acc);

        step(1'b1, map_a, 1'b1, acc);
        junk = rand_map();
        step(1'b1, junk, 1'b1, acc);
        step(1'b1, junk, 1'b1, acc);
        step(1'b1, junk, 1'b1, acc);
        step(1'b1, junk, 1'b0, acc);
        step(1'b1, junk, 1'b0, acc);
        step(1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, rand_map(), $urandom_range(0, 9) < 7, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
